dense_layer_seq: RTL and testbench

- Generalised successor to the binary-input dense layer: computes M neurons over an N-element signed multi-bit input vector.
- Weights and biases stream serially from a shared synchronous parameter ROM at a configurable base address, so several layers can share one ROM.
- Adds arithmetic requantisation shift, optional ReLU and optional output saturation.
- Sits between layers in the DNN chain, driven by a start/done handshake from the network sequencer.

---
 rtl/dense_pkg.sv | 42 ++++
 rtl/dense_layer_seq_requant.sv | 31 +++
 rtl/dense_layer_seq.sv | 161 ++++++++++++++++
 tb/tb_dense_layer_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and helpers for the sequential dense layer.
// Optional feature macro: DENSE_SATURATE_EN (output clamp instead of truncation).
package dense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Offset-binary word (up to 32 bits wide) to a sign-extended two's complement value.
  function automatic logic signed [31:0] ob_decode(input logic [31:0] raw,
                                                   input int unsigned bits);
    logic [31:0] flip;
    flip = raw ^ (32'd1 << (bits - 1));
    return signed'(flip << (32 - bits)) >>> (32 - bits);
  endfunction

  // Clamp a value into the signed range of a 'bits'-wide result.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // ROM layout: all weights row-major per neuron, then one bias per neuron.
  function automatic int unsigned rom_addr(input int unsigned base,
                                           input int unsigned j,
                                           input int unsigned i,
                                           input int unsigned n,
                                           input int unsigned m,
                                           input logic        is_bias);
    if (is_bias) return base + n * m + j;
    return base + j * n + i;
  endfunction

endpackage

// File: rtl/dense_layer_seq_requant.sv
// Combinational requantisation: arithmetic shift, bias add, optional ReLU,
// then saturation (DENSE_SATURATE_EN) or truncation to the output width.
module dense_requant
  import dense_pkg::*;
#(
  parameter int ACC_BITS = 32,
  parameter int OUT_BITS = 16,
  parameter int SHIFT    = 8,
  parameter int RELU_ON  = 1
) (
  input  logic signed [ACC_BITS-1:0] i_acc,
  input  logic signed [ACC_BITS-1:0] i_bias,
  output logic        [OUT_BITS-1:0] o_out
);

  logic signed [ACC_BITS-1:0] w_sum;
  logic signed [ACC_BITS-1:0] w_relu;

  // Shift (floor), add bias, rectify and narrow to the output width.
  always_comb begin
    w_sum  = (i_acc >>> SHIFT) + i_bias;
    w_relu = w_sum;
    if ((RELU_ON != 0) && w_sum[ACC_BITS-1]) w_relu = '0;
`ifdef DENSE_SATURATE_EN
    o_out = OUT_BITS'(sat_clamp(64'(w_relu), OUT_BITS));
`else
    o_out = OUT_BITS'(w_relu);
`endif
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: M neurons over N signed inputs, weights and biases
// streamed one per cycle from a shared synchronous ROM at BASE_ADDR.
// Optional feature macro: DENSE_SATURATE_EN (see dense_requant).
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int N          = 64,
  parameter int M          = 32,
  parameter int IN_BITS    = 16,
  parameter int W_BITS     = 8,
  parameter int ACC_BITS   = 32,
  parameter int OUT_BITS   = 16,
  parameter int SHIFT      = 8,
  parameter int RELU_ON    = 1,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*IN_BITS-1:0]    in_vec,
  input  logic [W_BITS-1:0]       mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_en,
  output logic [M*OUT_BITS-1:0]   out_vec,
  output logic                    busy,
  output logic                    done
);

  localparam int T    = M * (N + 1);
  localparam int CI_W = $clog2(N + 1) + 1;
  localparam int J_W  = $clog2(M) + 1;
  localparam int K_W  = $clog2(T + 1) + 1;
  localparam logic [CI_W-1:0]       N_C    = CI_W'(N);
  localparam logic [K_W-1:0]        T_C    = K_W'(T);
  localparam logic [ADDR_WIDTH-1:0] BASE_C = ADDR_WIDTH'(BASE_ADDR);

  if (BASE_ADDR + N * M + M > (1 << ADDR_WIDTH)) begin : g_rom_overflow
    $error("dense_layer_seq: layer parameters exceed the ROM address space");
  end

  state_t                     r_state;
  logic [N*IN_BITS-1:0]       r_x;
  logic signed [ACC_BITS-1:0] r_acc;
  logic [K_W-1:0]             r_k;
  logic [CI_W-1:0]            r_pi;
  logic [J_W-1:0]             r_pj;
  logic [CI_W-1:0]            r_ci;
  logic [J_W-1:0]             r_cj;
  logic [M*OUT_BITS-1:0]      r_out;
  logic                       r_done;
  logic                       r_busy;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic                       r_en;

  logic signed [IN_BITS-1:0]        w_x;
  logic signed [W_BITS-1:0]         w_w;
  logic signed [IN_BITS+W_BITS-1:0] w_prod;
  logic signed [ACC_BITS-1:0]       w_prod_ext;
  logic signed [ACC_BITS-1:0]       w_bias;
  logic        [OUT_BITS-1:0]       w_q;

  assign w_x        = signed'(r_x[r_ci*IN_BITS +: IN_BITS]);
  assign w_w        = W_BITS'(ob_decode(32'(mem_dout), W_BITS));
  assign w_prod     = w_x * w_w;
  assign w_prod_ext = ACC_BITS'(w_prod);
  assign w_bias     = ACC_BITS'(w_w);

  dense_requant #(
    .ACC_BITS (ACC_BITS),
    .OUT_BITS (OUT_BITS),
    .SHIFT    (SHIFT),
    .RELU_ON  (RELU_ON)
  ) u_requant (
    .i_acc  (r_acc),
    .i_bias (w_bias),
    .o_out  (w_q)
  );

  // Control FSM: presents item k in RUN cycle k, consumes item k-1 from the ROM in the same cycle.
  // Separate present (r_pj/r_pi) and consume (r_cj/r_ci) cursors track the one-cycle ROM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_pi    <= '0;
      r_pj    <= '0;
      r_ci    <= '0;
      r_cj    <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= BASE_C;
      r_en    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_addr <= BASE_C;
          r_en   <= 1'b0;
          if (start) begin
            r_x     <= in_vec;
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_k     <= '0;
            r_addr  <= ADDR_WIDTH'(rom_addr(BASE_ADDR, 0, 0, N, M, 1'b0));
            r_en    <= 1'b1;
            r_pj    <= '0;
            r_pi    <= CI_W'(1);
            r_cj    <= '0;
            r_ci    <= '0;
          end
        end
        RUN: begin
          r_k <= r_k + K_W'(1);
          if (r_k != '0) begin
            if (r_ci == N_C) begin
              r_out[r_cj*OUT_BITS +: OUT_BITS] <= w_q;
              r_ci <= '0;
              r_cj <= r_cj + J_W'(1);
            end else begin
              r_acc <= (r_ci == '0) ? w_prod_ext : r_acc + w_prod_ext;
              r_ci  <= r_ci + CI_W'(1);
            end
          end
          if (r_k + K_W'(1) < T_C) begin
            r_addr <= ADDR_WIDTH'(rom_addr(BASE_ADDR, 32'(r_pj), 32'(r_pi), N, M, r_pi == N_C));
            r_en   <= 1'b1;
            if (r_pi == N_C) begin
              r_pi <= '0;
              r_pj <= r_pj + J_W'(1);
            end else begin
              r_pi <= r_pi + CI_W'(1);
            end
          end else begin
            r_addr <= BASE_C;
            r_en   <= 1'b0;
          end
          if (r_k == T_C) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr = r_addr;
  assign mem_en   = r_en;
  assign out_vec  = r_out;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: three instances (N=4, M=2, 8-bit data, BASE_ADDR=100)
// with different ReLU/shift settings share one ROM image and one stimulus stream.
module tb_dense_layer_seq;

  localparam int ND = 3;
  localparam int RELU_T [ND] = '{1, 0, 0};
  localparam int SH_T   [ND] = '{0, 0, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_vec;
  logic [11:0] maddr [ND];
  logic        men   [ND];
  logic [7:0]  dout  [ND];
  logic [15:0] ovec  [ND];
  logic        busy  [ND];
  logic        done  [ND];

  logic [7:0]  rom [0:4095];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Synchronous ROM, one read port per instance.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++)
      if (men[d]) dout[d] <= rom[maddr[d]];
  end

  dense_layer_seq #(.N(4), .M(2), .IN_BITS(8), .W_BITS(8), .ACC_BITS(32), .OUT_BITS(8),
                    .SHIFT(0), .RELU_ON(1), .ADDR_WIDTH(12), .BASE_ADDR(100)) u_d0 (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .mem_dout(dout[0]),
    .mem_addr(maddr[0]), .mem_en(men[0]), .out_vec(ovec[0]), .busy(busy[0]), .done(done[0]));

  dense_layer_seq #(.N(4), .M(2), .IN_BITS(8), .W_BITS(8), .ACC_BITS(32), .OUT_BITS(8),
                    .SHIFT(0), .RELU_ON(0), .ADDR_WIDTH(12), .BASE_ADDR(100)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .mem_dout(dout[1]),
    .mem_addr(maddr[1]), .mem_en(men[1]), .out_vec(ovec[1]), .busy(busy[1]), .done(done[1]));

  dense_layer_seq #(.N(4), .M(2), .IN_BITS(8), .W_BITS(8), .ACC_BITS(32), .OUT_BITS(8),
                    .SHIFT(4), .RELU_ON(0), .ADDR_WIDTH(12), .BASE_ADDR(100)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .mem_dout(dout[2]),
    .mem_addr(maddr[2]), .mem_en(men[2]), .out_vec(ovec[2]), .busy(busy[2]), .done(done[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offset-binary value: stored code minus half range.
  function automatic int ob(input logic [7:0] b);
    return int'(b) - 128;
  endfunction

  // Reference neuron j for a given ReLU/shift setting, from the ROM image and inputs.
  function automatic logic [7:0] model(input int relu, input int sh, input int j,
                                       input logic [31:0] xv);
    int acc, q, y, div;
    logic signed [7:0] xe;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      xe  = xv[i*8 +: 8];
      acc = acc + int'(xe) * ob(rom[100 + j*4 + i]);
    end
    div = 1 << sh;
    q   = acc / div;
    if ((acc % div != 0) && (acc < 0)) q = q - 1;
    y = q + ob(rom[108 + j]);
    if (relu != 0 && y < 0) y = 0;
`ifdef DENSE_SATURATE_EN
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
`endif
    return y[7:0];
  endfunction

  // mode 0: plain run, 1: start/in_vec disturbed during RUN/DONE, 2: reset at RUN cycle 5.
  task automatic run_layer(input logic [31:0] x, input int mode);
    int          done_cnt [ND];
    int          done_e;
    int          en_cnt;
    logic [31:0] xl;
    int          exp_addr [11];
    exp_addr = '{100, 101, 102, 103, 108, 104, 105, 106, 107, 109, 100};
    foreach (done_cnt[d]) done_cnt[d] = 0;
    done_e = -1;
    en_cnt = 0;
    xl     = x;
    @(negedge clk);
    in_vec = x;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // Sample index e: value held just before clock edge e (edge 0 samples start).
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        if (done[d] === 1'b1) begin
          done_cnt[d]++;
          if (d == 0) done_e = e;
        end
      if (men[0] === 1'b1) en_cnt++;
      if (mode != 2 && e <= 11) begin
        chk($sformatf("addr_e%0d", e), 32'(maddr[0]), 32'(exp_addr[e-1]));
        chk($sformatf("en_e%0d", e), 32'(men[0]), (e <= 10) ? 32'd1 : 32'd0);
      end
      if (mode != 2 && e <= 13)
        chk($sformatf("busy_e%0d", e), 32'(busy[0]), (e <= 12) ? 32'd1 : 32'd0);
      if (mode == 1 && e == 4) begin start = 1'b1; in_vec = $urandom; end
      if (mode == 1 && e == 5) start = 1'b0;
      if (mode == 1 && e == 12) start = 1'b1;
      if (mode == 1 && e == 13) start = 1'b0;
      if (mode == 2 && e == 6) begin
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("rstmid_out_d%0d", d), 32'(ovec[d]), 32'd0);
          chk($sformatf("rstmid_busy_d%0d", d), 32'(busy[d]), 32'd0);
          chk($sformatf("rstmid_en_d%0d", d), 32'(men[d]), 32'd0);
          chk($sformatf("rstmid_addr_d%0d", d), 32'(maddr[d]), 32'd100);
        end
      end
      if (mode == 2 && e == 7) rst = 1'b0;
    end
    if (mode == 2) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("rstmid_nodone_d%0d", d), 32'(done_cnt[d]), 32'd0);
        chk($sformatf("rstmid_idle_d%0d", d), 32'(busy[d]), 32'd0);
      end
    end else begin
      chk("done_edge", 32'(done_e), 32'd12);
      chk("en_count", 32'(en_cnt), 32'd10);
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("done_cnt_d%0d", d), 32'(done_cnt[d]), 32'd1);
        for (int j = 0; j < 2; j++)
          chk($sformatf("out_d%0d_n%0d", d, j), 32'(ovec[d][j*8 +: 8]),
              32'(model(RELU_T[d], SH_T[d], j, xl)));
      end
    end
  endtask

  task automatic fill_rom(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < 4; i++) begin
      rom[100 + i] = w0;
      rom[104 + i] = w1;
    end
    rom[108] = b0;
    rom[109] = b1;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    in_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_out_d%0d", d), 32'(ovec[d]), 32'd0);
      chk($sformatf("reset_busy_d%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("reset_done_d%0d", d), 32'(done[d]), 32'd0);
      chk($sformatf("reset_en_d%0d", d), 32'(men[d]), 32'd0);
      chk($sformatf("reset_addr_d%0d", d), 32'(maddr[d]), 32'd100);
    end
    @(negedge clk);
    rst = 1'b0;

    // Basic neuron values.
    fill_rom(8'h81, 8'h7F, 8'h85, 8'h80);
    run_layer({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    chk("basic_relu_out0", 32'(ovec[0][7:0]), 32'd15);
    chk("basic_relu_out1", 32'(ovec[0][15:8]), 32'd0);
    chk("basic_norelu_out1", 32'(ovec[1][15:8]), 32'hF6);

    // Large accumulator: saturation or truncation.
    fill_rom(8'hFF, 8'hFF, 8'h80, 8'h80);
    run_layer({4{8'd127}}, 0);
`ifdef DENSE_SATURATE_EN
    chk("sat_out0", 32'(ovec[1][7:0]), 32'd127);
`else
    chk("trunc_out0", 32'(ovec[1][7:0]), 32'd4);
`endif

    // Floor shift of a negative accumulator.
    fill_rom(8'h81, 8'h81, 8'h80, 8'h80);
    run_layer({8'd0, 8'd0, 8'd0, 8'hEF}, 0);
    chk("shift_out0", 32'(ovec[2][7:0]), 32'hFE);

    // Random weights, biases and inputs.
    repeat (6) begin
      for (int a = 100; a < 110; a++) rom[a] = 8'($urandom);
      run_layer($urandom, 0);
    end

    // start and in_vec changes while busy are ignored.
    for (int a = 100; a < 110; a++) rom[a] = 8'($urandom);
    run_layer($urandom, 1);

    // Reset mid-run, then a clean run.
    for (int a = 100; a < 110; a++) rom[a] = 8'($urandom);
    run_layer($urandom, 2);
    run_layer($urandom, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
